// File: rtl/cim_layer_seq_pkg.sv
// Shared types and defaults for the CIM layer sequencer.
// The optional watchdog is enabled by defining CIM_LAYER_SEQ_WATCHDOG_EN.
package cim_layer_seq_pkg;

    localparam int NUM_LAYERS_DEFAULT = 11;
    localparam int TIMEOUT_W_DEFAULT  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RUN,
        HAND
    } seq_state_t;

endpackage

// File: rtl/cim_layer_seq_stage.sv
// One pipeline stage of the layer sequencer: a Moore FSM plus an optional RUN watchdog.
// The watchdog exists only when CIM_LAYER_SEQ_WATCHDOG_EN is defined.
import cim_layer_seq_pkg::*;

module cim_layer_seq_stage #(
    parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tok_in,
    input  logic i_down_idle,
    input  logic i_busy,
    output logic o_is_idle,
    output logic o_is_hand,
    output logic o_start,
    output logic o_func_start,
    output logic o_error
);

    seq_state_t r_state;
    seq_state_t w_state_next;
    logic       w_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Busy release wins over a coincident watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_tok_in) w_state_next = START;
            START:   w_state_next = WAIT;
            WAIT:    w_state_next = RUN;
            RUN: begin
                if (!i_busy) begin
                    w_state_next = HAND;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            HAND:    if (i_down_idle) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign o_is_idle    = (r_state == IDLE);
    assign o_is_hand    = (r_state == HAND);
    assign o_start      = (r_state == START);
    assign o_func_start = (r_state == HAND) & i_down_idle;

`ifdef CIM_LAYER_SEQ_WATCHDOG_EN
    // Expiry fires on the cycle the count would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));

    logic [TIMEOUT_W-1:0] r_wd_cnt;
    logic                 r_error;

    assign w_timeout = (r_state == RUN) & i_busy & (r_wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            if (r_state != RUN) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
`endif

endmodule

// File: rtl/cim_layer_sequencer.sv
// Frame-level scheduler: a chain of stage FSMs passing a frame token layer to layer.
// Define CIM_LAYER_SEQ_WATCHDOG_EN to enable per-stage RUN timeouts and o_error.
import cim_layer_seq_pkg::*;

module cim_layer_sequencer #(
    parameter int NUM_LAYERS = NUM_LAYERS_DEFAULT,
    parameter int TIMEOUT_W  = TIMEOUT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_frame_valid,
    output logic                  o_frame_ready,
    input  logic [NUM_LAYERS-1:0] i_layer_busy,
    input  logic                  i_sink_busy,
    output logic [NUM_LAYERS-1:0] o_start,
    output logic [NUM_LAYERS-1:0] o_func_start,
    output logic [NUM_LAYERS-1:0] o_next_busy,
    output logic                  o_frame_done,
    output logic [NUM_LAYERS-1:0] o_error
);

    logic [NUM_LAYERS-1:0] w_idle;
    logic [NUM_LAYERS-1:0] w_hand;
    logic [NUM_LAYERS-1:0] w_tok_in;
    logic [NUM_LAYERS-1:0] w_down_idle;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_tok_in[gi] = i_frame_valid & w_idle[gi];
            end else begin : g_chain
                assign w_tok_in[gi] = w_hand[gi-1] & w_idle[gi];
            end

            // Neighbours see only each other's registered state, so no loop forms.
            if (gi == NUM_LAYERS - 1) begin : g_last
                assign w_down_idle[gi] = ~i_sink_busy;
                assign o_next_busy[gi] = i_sink_busy;
            end else begin : g_inner
                assign w_down_idle[gi] = w_idle[gi+1];
                assign o_next_busy[gi] = ~w_idle[gi+1];
            end

            cim_layer_seq_stage #(
                .TIMEOUT_W (TIMEOUT_W)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .i_tok_in     (w_tok_in[gi]),
                .i_down_idle  (w_down_idle[gi]),
                .i_busy       (i_layer_busy[gi]),
                .o_is_idle    (w_idle[gi]),
                .o_is_hand    (w_hand[gi]),
                .o_start      (o_start[gi]),
                .o_func_start (o_func_start[gi]),
                .o_error      (o_error[gi])
            );
        end
    endgenerate

    assign o_frame_ready = w_idle[0];
    assign o_frame_done  = o_func_start[NUM_LAYERS-1];

endmodule

// File: tb/tb_cim_layer_sequencer.sv
// Self-checking bench: occupancy/age model of the frame pipeline plus directed scenarios.
// Watchdog scenario runs only when CIM_LAYER_SEQ_WATCHDOG_EN is defined.
module tb_cim_layer_sequencer;

    localparam int NL = 11;
`ifdef CIM_LAYER_SEQ_WATCHDOG_EN
    localparam int TW    = 4;
    localparam bit WD_EN = 1'b1;
`else
    localparam int TW    = 16;
    localparam bit WD_EN = 1'b0;
`endif
    localparam int WD_MAX = (2 ** TW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_valid = 1'b0;
    logic [NL-1:0] layer_busy = '0;
    logic          sink_busy = 1'b0;
    logic          frame_ready;
    logic [NL-1:0] start_o, func_o, next_busy_o, error_o;
    logic          frame_done;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cim_layer_sequencer #(
        .NUM_LAYERS (NL),
        .TIMEOUT_W  (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (frame_valid),
        .o_frame_ready (frame_ready),
        .i_layer_busy  (layer_busy),
        .i_sink_busy   (sink_busy),
        .o_start       (start_o),
        .o_func_start  (func_o),
        .o_next_busy   (next_busy_o),
        .o_frame_done  (frame_done),
        .o_error       (error_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: each layer either holds a frame (with its age in cycles since the
    // token arrived and whether its work is finished) or is empty.
    bit m_occ [NL];
    bit m_done[NL];
    bit m_err [NL];
    int m_age [NL];

    function automatic bit down_free(int k);
        if (k == NL - 1) return !sink_busy;
        return !m_occ[k+1];
    endfunction

    always @(posedge clk) begin : model
        bit f[NL];
        if (!rst) begin
            for (int k = 0; k < NL; k++) begin
                m_occ[k] = 0; m_done[k] = 0; m_err[k] = 0; m_age[k] = 0;
            end
        end else begin
            for (int k = 0; k < NL; k++) f[k] = m_occ[k] && m_done[k] && down_free(k);
            for (int k = 0; k < NL; k++) begin
                if (m_occ[k]) begin
                    if (f[k]) begin
                        m_occ[k] = 0; m_done[k] = 0;
                    end else begin
                        // Age 1 = start pulse, 2 = busy ignored, 3+ = working.
                        if (!m_done[k] && m_age[k] >= 3) begin
                            if (!layer_busy[k]) m_done[k] = 1;
                            else if (WD_EN && (m_age[k] - 2) == WD_MAX) begin
                                m_occ[k] = 0; m_err[k] = 1;
                            end
                        end
                        m_age[k] = m_age[k] + 1;
                    end
                end else if ((k == 0) ? frame_valid : f[k-1]) begin
                    m_occ[k] = 1; m_done[k] = 0; m_age[k] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [NL-1:0] e_start, e_func, e_nb, e_err;
        if (chk_en) begin
            for (int k = 0; k < NL; k++) begin
                e_start[k] = m_occ[k] && (m_age[k] == 1);
                e_func[k]  = m_occ[k] && m_done[k] && down_free(k);
                e_nb[k]    = (k == NL - 1) ? sink_busy : m_occ[k+1];
                e_err[k]   = m_err[k];
            end
            chk("cmp_start", start_o, e_start);
            chk("cmp_func_start", func_o, e_func);
            chk("cmp_next_busy", next_busy_o, e_nb);
            chk("cmp_error", error_o, e_err);
            chk("cmp_frame_ready", frame_ready, !m_occ[0]);
            chk("cmp_frame_done", frame_done, e_func[NL-1]);
        end
    end

    task automatic do_reset();
        frame_valid = 0; layer_busy = '0; sink_busy = 0; rst = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 1;
    endtask

    // Cycle c ends at edge c; inputs for cycle c are applied just after edge c-1.
    task automatic run(input int scn, input int ncyc);
        int fs_cnt[NL];
        int st_cnt[NL];
        int dones, accepts, last_acc, last_done, quiet;
        dones = 0; accepts = 0; last_acc = -1; last_done = -1; quiet = 0;
        for (int k = 0; k < NL; k++) begin fs_cnt[k] = 0; st_cnt[k] = 0; end
        for (int c = 0; c < ncyc; c++) begin
            frame_valid = 0; layer_busy = '0; sink_busy = 0; rst = 1;
            case (scn)
                1: frame_valid = (c == 0);
                2: begin frame_valid = (c <= 5); layer_busy[2] = (c >= 11 && c <= 20); end
                3: begin frame_valid = (c <= 5); sink_busy = (c >= 44 && c <= 63); end
                4: frame_valid = (c < 60);
                5: begin frame_valid = (c <= 12) || (c == 20); rst = !(c == 14); end
                6: begin frame_valid = (c == 0); layer_busy[5] = (c >= 22); end
                default: ;
            endcase
            @(negedge clk);
            for (int k = 0; k < NL; k++) begin
                fs_cnt[k] += int'(func_o[k]);
                st_cnt[k] += int'(start_o[k]);
            end
            if (frame_valid && frame_ready) begin
                if (scn == 4 && last_acc >= 0) chk("s4_accept_gap", c - last_acc, 5);
                accepts++; last_acc = c;
            end
            if (frame_done) begin
                if (scn == 4 && last_done >= 0) chk("s4_done_gap", c - last_done, 5);
                dones++; last_done = c;
            end
            case (scn)
                1: begin
                    if (c == 1) chk("s1_start0_c1", start_o[0], 1);
                    if (c == 5) chk("s1_start1_c5", start_o[1], 1);
                    for (int k = 0; k < NL; k++)
                        if (c == 4 * k + 4) chk($sformatf("s1_func%0d_c%0d", k, c), func_o[k], 1);
                    if (c == 44) chk("s1_done_c44", frame_done, 1);
                end
                2: begin
                    if (c == 12) chk("s2_func2_c12", func_o[2], 0);
                    if (c == 22) chk("s2_func2_c22", func_o[2], 1);
                    if (c == 15) chk("s2_next_busy1_c15", next_busy_o[1], 1);
                    if (c == 22) chk("s2_func1_c22", func_o[1], 0);
                    if (c == 23) chk("s2_func1_c23", func_o[1], 1);
                end
                3: begin
                    if (c == 44) chk("s3_done_c44", frame_done, 0);
                    if (c == 50) chk("s3_next_busy9_c50", next_busy_o[9], 1);
                    if (c == 64) chk("s3_done_c64", frame_done, 1);
                    if (c == 64) chk("s3_func9_c64", func_o[9], 0);
                    if (c == 65) chk("s3_func9_c65", func_o[9], 1);
                    if (c == 69) chk("s3_done_c69", frame_done, 1);
                end
                5: begin
                    if (c == 15) begin
                        chk("s5_start_c15", start_o, 0);
                        chk("s5_func_c15", func_o, 0);
                        chk("s5_ready_c15", frame_ready, 1);
                        chk("s5_next_busy_c15", next_busy_o, 0);
                    end
                    if (c >= 15 && c <= 19) quiet += int'(|start_o) + int'(|func_o);
                    if (c == 21) chk("s5_start0_c21", start_o[0], 1);
                    if (c == 64) chk("s5_done_c64", frame_done, 1);
                end
                6: begin
                    if (c == 37) chk("s6_err5_c37", error_o[5], 0);
                    if (c == 38) chk("s6_err5_c38", error_o[5], 1);
                    if (c == ncyc - 1) chk("s6_err5_sticky", error_o[5], 1);
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        frame_valid = 0; layer_busy = '0; sink_busy = 0; rst = 1;
        case (scn)
            1: for (int k = 0; k < NL; k++) begin
                chk($sformatf("s1_func_pulses%0d", k), fs_cnt[k], 1);
                chk($sformatf("s1_start_pulses%0d", k), st_cnt[k], 1);
            end
            2: chk("s2_dones", dones, 2);
            3: chk("s3_dones", dones, 2);
            4: begin chk("s4_accepts", accepts, 12); chk("s4_dones", dones, 12); end
            5: begin chk("s5_quiet", quiet, 0); chk("s5_dones", dones, 1); end
            6: begin chk("s6_func5_pulses", fs_cnt[5], 0); chk("s6_dones", dones, 0); end
            default: ;
        endcase
        $display("scenario %0d: accepts=%0d frame_done=%0d", scn, accepts, dones);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("reset_ready", frame_ready, 1);
        chk("reset_start", start_o, 0);
        chk("reset_error", error_o, 0);
        @(posedge clk); #1;
        run(1, 50);
        do_reset();
        run(2, 100);
        do_reset();
        run(3, 100);
        do_reset();
        run(4, 130);
        do_reset();
        run(5, 80);
`ifdef CIM_LAYER_SEQ_WATCHDOG_EN
        do_reset();
        run(6, 60);
        do_reset();
        @(negedge clk);
        chk("s6_err_cleared", error_o, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cim_layer_sequencer.md
# cim_layer_sequencer

Frame-level scheduler for the CIM inference pipeline. It sits beside the top-level chain of conv, pool and fc layers and drives each layer's `i_start`, `i_func_start` and `i_next_busy` from per-layer busy status. A frame token passes from layer to layer, so different frames can occupy different layers at the same time, and each layer handshakes with its successor before releasing its output.

## Interface
Parameters:
- `NUM_LAYERS`, 11: number of sequenced layers, in pipeline order.
- `TIMEOUT_W`, 16: width of the per-stage watchdog counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low.
- `i_frame_valid` in 1: a new frame's input is loaded into layer 0's buffer.
- `o_frame_ready` out 1: layer 0 can accept a frame. A frame is accepted when valid and ready are both high.
- `i_layer_busy` in `NUM_LAYERS`: each layer's `o_busy`. Pool layers tie their bit to 0.
- `i_sink_busy` in 1: consumer of the last layer is busy.
- `o_start` out `NUM_LAYERS`: one-cycle start pulse per layer.
- `o_func_start` out `NUM_LAYERS`: one-cycle output-function pulse per layer.
- `o_next_busy` out `NUM_LAYERS`: drives each layer's `i_next_busy`.
- `o_frame_done` out 1: one-cycle pulse when the last layer releases a frame.
- `o_error` out `NUM_LAYERS`: sticky watchdog flags.

## Operation
- Each layer k has its own stage FSM with states IDLE, START, WAIT, RUN, HAND. All outputs are decoded from the registered state (Moore).
- Token in:
  - Stage 0: `tok_in = i_frame_valid & o_frame_ready`.
  - Stage k>0: `tok_in = (stage k-1 == HAND) & (stage k == IDLE)`.
- Transitions:
  - IDLE → START on `tok_in`.
  - START → WAIT unconditionally. `o_start[k]` is 1 while in START.
  - WAIT → RUN unconditionally. Busy is ignored in WAIT, which absorbs the layer's busy-rise latency.
  - RUN → HAND when `i_layer_busy[k] == 0`.
  - HAND → IDLE when the downstream stage is IDLE. For the last stage, the condition is `!i_sink_busy`.
  - `o_func_start[k]` is 1 in exactly the HAND cycle that meets this condition.
- `o_next_busy[k]` = (stage k+1 != IDLE) for k < NUM_LAYERS-1. `o_next_busy[NUM_LAYERS-1]` = `i_sink_busy`.
- `o_frame_ready` = (stage 0 == IDLE).
- `o_frame_done` = last-stage `o_func_start`.
- Stages decide on registered neighbour state only:
  - A stage leaving HAND is not IDLE in that cycle, so its upstream waits at least one more cycle.
  - No combinational loop exists between stages.
- Holding `i_frame_valid` high while `o_frame_ready` is low has no effect.

## Timing
- Reset (`rst` low at a clock edge): every stage goes to IDLE on the next edge.
  - `o_start`, `o_func_start`, `o_frame_done` and `o_error` are 0.
  - `o_frame_ready` is 1.
  - `o_next_busy` is 0, apart from the last bit, which follows `i_sink_busy`.
- Reset mid-frame discards all tokens and issues no pulses.
- Per-stage minimum latency is 4 cycles (START, WAIT, RUN, HAND) when busy is low and downstream is free.
- Accept at edge 0: `o_start[0]` high in cycle 1, `o_func_start[0]` in cycle 4, `o_start[1]` in cycle 5.
- The last-layer handoff and `o_frame_done` fall in cycle 4·NUM_LAYERS, which is 44 at the default.
- Throughput: stage 0 can accept a new frame 5 cycles after the previous accept, given no stall.
- A pulse is never longer than one cycle. `o_start[k]` and `o_func_start[k]` are never high in the same cycle.

## Configuration
- With `CIM_LAYER_SEQ_WATCHDOG_EN` defined:
  - Each stage counts cycles spent in RUN.
  - On reaching 2^TIMEOUT_W−1, `o_error[k]` sets (sticky until reset) and the stage goes directly to IDLE without a `o_func_start`, dropping the frame.
  - The counter clears on entry to RUN.
- Without the macro, no counters are instantiated, `o_error` is tied to 0 and RUN waits indefinitely.

## Structure
- Package `cim_layer_seq_pkg`:
  - stage state enum typedef `seq_state_t` (IDLE, START, WAIT, RUN, HAND);
  - default `TIMEOUT_W` localparam.
- Sub-module `cim_layer_seq_stage`:
  - contains one FSM and the optional watchdog;
  - instantiated `NUM_LAYERS` times with a generate loop;
  - neighbour connections: `tok_in` and `down_idle` in, `is_idle`/`is_hand` out.
- The top level only wires the chain and the frame-port glue.

## Test plan
- Single frame, all busy 0, sink free, `NUM_LAYERS`=11 → `o_start[0]` cycle 1, `o_func_start[k]` at cycle 4k+4, `o_frame_done` at cycle 44, exactly one pulse per layer.
- Layer 2 busy held 10 cycles after its WAIT → `o_func_start[2]` is delayed 10 cycles; second frame accepted, stage 1 parks in HAND with `o_next_busy[1]` = 1 until stage 2 returns to IDLE.
- `i_sink_busy` high for 20 cycles at last-stage HAND → `o_frame_done` waits and upstream stages back up in HAND; release gives one `o_frame_done` and ordered draining.
- Back-to-back `i_frame_valid` held high → accepts spaced 5 cycles, `o_frame_done` every 5 cycles once in steady state, no lost or duplicated frames.
- `rst` low while 3 frames are in flight → all outputs at reset values next cycle, no further pulses, a fresh frame completes in 44 cycles.
- With the watchdog macro and `TIMEOUT_W`=4, layer 5 stuck busy → `o_error[5]` sets after 15 RUN cycles, stage 5 returns to IDLE, no `o_func_start[5]`, and the flag stays set until reset.
